// File: rtl/reci_fp32_ctrl.sv
// fp32 reciprocal controller: decodes x, handles specials, sequences the
// external mantissa reciprocal engine over LAT cycles and returns 1/x.
// Ports: clk, rst (async, active-high); s_valid/s_ready/s_data operand in;
//   m_valid/m_ready/m_data/m_flags {invalid,div_by_zero,underflow} result out;
//   o_X mantissa to engine, i_result engine reciprocal fraction.
module reci_fp32_ctrl #(
  parameter int FLT_WIDTH = 23,
  parameter int LAT       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [31:0]          s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [31:0]          m_data,
  output logic [2:0]           m_flags,
  output logic [FLT_WIDTH-1:0] o_X,
  input  logic [FLT_WIDTH-1:0] i_result
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(LAT - 1);

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   sign_q, sign_d;
  logic [7:0]             exp_q, exp_d;
  logic [FLT_WIDTH-1:0]   frac_q, frac_d;
  logic [31:0]            data_q, data_d;
  logic [2:0]             flags_q, flags_d;

  logic                   in_s;
  logic [7:0]             in_e;
  logic [FLT_WIDTH-1:0]   in_f;
  logic                   f_zero;
  logic                   zero_in, inf_in, nan_in;
  logic                   uflow_in, pow2_in;
  logic [7:0]             e_pow2, e_norm;

  assign in_s = s_data[31];
  assign in_e = s_data[30:FLT_WIDTH];
  assign in_f = s_data[FLT_WIDTH-1:0];

  assign f_zero   = (in_f == '0);
  assign zero_in  = (in_e == 8'd0);
  assign inf_in   = (in_e == 8'd255) && f_zero;
  assign nan_in   = (in_e == 8'd255) && !f_zero;
  // Result exponent would be <= 0: flush to signed zero.
  assign uflow_in = ((in_e == 8'd254) || (in_e == 8'd253)) && !f_zero;
  // Exact powers of two need no engine: answer is known at accept.
  assign pow2_in  = (in_e != 8'd0) && (in_e != 8'd255) && f_zero;

  // Low 8 bits of the unsigned 9-bit difference.
  assign e_pow2 = 8'd254 - in_e;
  assign e_norm = 8'd253 - exp_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    frac_d  = frac_q;
    data_d  = data_q;
    flags_d = flags_q;
    s_ready = 1'b0;
    m_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          sign_d  = in_s;
          exp_d   = in_e;
          frac_d  = in_f;
          cnt_d   = 4'd0;
          state_d = DONE;
          flags_d = 3'b000;
          unique case (1'b1)
            zero_in: begin
              data_d  = {in_s, 8'hFF, {FLT_WIDTH{1'b0}}};
              flags_d = 3'b010;
            end
            inf_in: begin
              data_d = {in_s, 31'd0};
            end
            nan_in: begin
              data_d  = 32'h7FC0_0000;
              flags_d = 3'b100;
            end
            uflow_in: begin
              data_d  = {in_s, 31'd0};
              flags_d = 3'b001;
            end
            pow2_in: begin
              data_d = {in_s, e_pow2, {FLT_WIDTH{1'b0}}};
            end
            default: begin
              state_d = WAIT;
            end
          endcase
        end
      end
      WAIT: begin
        if (cnt_q == LAST) begin
          data_d  = {sign_q, e_norm, i_result};
          flags_d = 3'b000;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        m_valid = 1'b1;
        if (m_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sign_q  <= 1'b0;
      exp_q   <= 8'd0;
      frac_q  <= '0;
      data_q  <= 32'd0;
      flags_q <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      frac_q  <= frac_d;
      data_q  <= data_d;
      flags_q <= flags_d;
    end
  end

  assign o_X     = frac_q;
  assign m_data  = data_q;
  assign m_flags = flags_q;

endmodule
